// File: rtl/fetch_queue.sv
// Fetch-to-decode decoupling FIFO. It holds instructions and their PCs, and it
// supports branch flushes that can optionally keep the head as a delay slot.
module fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_instr,
    input  logic [ADDR_W-1:0]        in_pc,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_instr,
    output logic [ADDR_W-1:0]        out_pc,
    input  logic                     out_ready,
    input  logic                     flush,
    input  logic                     flush_keep_head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] instrMem_q [DEPTH];
    logic [ADDR_W-1:0] pcMem_q    [DEPTH];

    logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic full, empty, push, pop, wrEn;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = in_valid & ~full;
    assign pop   = ~empty & out_ready;

    assign in_ready  = ~full;
    assign out_valid = ~empty;
    assign count     = count_q;
    assign out_instr = empty ? '0 : instrMem_q[rdPtr_q];
    assign out_pc    = empty ? '0 : pcMem_q[rdPtr_q];

    // A flush takes priority over push and pop. The only push that survives a
    // flush is the delay-slot push into an empty queue under flush_keep_head.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        wrEn    = 1'b0;
        if (flush) begin
            if (!flush_keep_head) begin
                wrPtr_d = rdPtr_q;
                count_d = '0;
            end else if (empty) begin
                if (push) begin
                    wrEn    = 1'b1;
                    wrPtr_d = wrPtr_q + PTR_W'(1);
                    count_d = CNT_W'(1);
                end
            end else if (pop) begin
                rdPtr_d = rdPtr_q + PTR_W'(1);
                wrPtr_d = rdPtr_q + PTR_W'(1);
                count_d = '0;
            end else begin
                wrPtr_d = rdPtr_q + PTR_W'(1);
                count_d = CNT_W'(1);
            end
        end else begin
            if (push) begin
                wrEn    = 1'b1;
                wrPtr_d = wrPtr_q + PTR_W'(1);
            end
            if (pop) begin
                rdPtr_d = rdPtr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Storage is deliberately left unreset. The empty mask on the outputs hides stale data.
    always_ff @(posedge clk) begin
        if (rst && wrEn) begin
            instrMem_q[wrPtr_q] <= in_instr;
            pcMem_q[wrPtr_q]    <= in_pc;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue at DEPTH=4. Each scenario task
// drives stimulus and compares outputs against hand-computed values.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready;
    logic        flush;
    logic        flush_keep_head;
    logic [2:0]  count;

    int errors = 0;
    int checks = 0;

    fetch_queue #(.DEPTH(4), .DATA_W(32), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc), .in_ready(in_ready),
        .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc), .out_ready(out_ready),
        .flush(flush), .flush_keep_head(flush_keep_head), .count(count)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; flush_keep_head = 1'b0;
    endtask

    task automatic pushOne(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1; in_instr = instr; in_pc = pc; out_ready = 1'b0;
        tick();
        idle();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle();
        in_instr = '0; in_pc = '0;
        tick(); tick();
        rst = 1'b1;
        checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL reset_count got=%0d exp=0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_instr !== 32'h0) begin errors++; $display("[TB] FAIL reset_out_instr got=%h exp=0", out_instr); end
        checks++; if (out_pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_out_pc got=%h exp=0", out_pc); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            pushOne(32'hA000_0001 + 32'(i), 32'(i));
            checks++; if (count !== 3'(i + 1)) begin errors++; $display("[TB] FAIL fill_count[%0d] got=%0d exp=%0d", i, count, i + 1); end
            checks++; if (out_instr !== 32'hA000_0001) begin errors++; $display("[TB] FAIL fill_head[%0d] got=%h exp=a0000001", i, out_instr); end
            checks++; if (out_pc !== 32'h0) begin errors++; $display("[TB] FAIL fill_pc[%0d] got=%h exp=0", i, out_pc); end
        end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_in_ready got=%b exp=0", in_ready); end
        pushOne(32'hDEAD_0005, 32'h4);
        checks++; if (count !== 3'd4) begin errors++; $display("[TB] FAIL overfill_count got=%0d exp=4", count); end
        checks++; if (out_instr !== 32'hA000_0001) begin errors++; $display("[TB] FAIL overfill_head got=%h exp=a0000001", out_instr); end
    endtask

    task automatic test_drain_wrap();
        logic [31:0] expInstr [4];
        logic [31:0] expPc [4];
        expInstr[0] = 32'hA000_0003; expPc[0] = 32'h2;
        expInstr[1] = 32'hA000_0004; expPc[1] = 32'h3;
        expInstr[2] = 32'h0000_00B0; expPc[2] = 32'h100;
        expInstr[3] = 32'h0000_00B1; expPc[3] = 32'h104;
        for (int i = 0; i < 2; i++) begin
            checks++; if (out_instr !== 32'hA000_0001 + 32'(i)) begin errors++; $display("[TB] FAIL drain_head[%0d] got=%h exp=%h", i, out_instr, 32'hA000_0001 + 32'(i)); end
            out_ready = 1'b1;
            tick();
            idle();
        end
        checks++; if (count !== 3'd2) begin errors++; $display("[TB] FAIL drain_count got=%0d exp=2", count); end
        pushOne(32'hB0, 32'h100);
        pushOne(32'hB1, 32'h104);
        checks++; if (count !== 3'd4) begin errors++; $display("[TB] FAIL wrap_count got=%0d exp=4", count); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_instr !== expInstr[i]) begin errors++; $display("[TB] FAIL wrap_order[%0d] got=%h exp=%h", i, out_instr, expInstr[i]); end
            checks++; if (out_pc !== expPc[i]) begin errors++; $display("[TB] FAIL wrap_pc[%0d] got=%h exp=%h", i, out_pc, expPc[i]); end
            out_ready = 1'b1;
            tick();
            idle();
        end
        checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL empty_count got=%0d exp=0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL empty_valid got=%b exp=0", out_valid); end
        checks++; if (out_instr !== 32'h0) begin errors++; $display("[TB] FAIL empty_instr got=%h exp=0", out_instr); end
    endtask

    task automatic test_back_to_back();
        pushOne(32'hC0, 32'h200);
        pushOne(32'hC1, 32'h204);
        in_valid = 1'b1; in_instr = 32'hC2; in_pc = 32'h208; out_ready = 1'b1;
        tick();
        idle();
        checks++; if (count !== 3'd2) begin errors++; $display("[TB] FAIL pushpop_count got=%0d exp=2", count); end
        checks++; if (out_instr !== 32'hC1) begin errors++; $display("[TB] FAIL pushpop_head got=%h exp=c1", out_instr); end
        out_ready = 1'b1; tick(); idle();
        checks++; if (out_instr !== 32'hC2) begin errors++; $display("[TB] FAIL pushpop_next got=%h exp=c2", out_instr); end
        out_ready = 1'b1; tick(); idle();
        in_valid = 1'b1; in_instr = 32'hC3; in_pc = 32'h20C; out_ready = 1'b1;
        tick();
        idle();
        checks++; if (count !== 3'd1) begin errors++; $display("[TB] FAIL empty_pushpop_count got=%0d exp=1", count); end
        checks++; if (out_instr !== 32'hC3) begin errors++; $display("[TB] FAIL empty_pushpop_head got=%h exp=c3", out_instr); end
        out_ready = 1'b1; tick(); idle();
    endtask

    task automatic test_flush();
        pushOne(32'hD0, 32'h300);
        pushOne(32'hD1, 32'h304);
        pushOne(32'hD2, 32'h308);
        flush = 1'b1; flush_keep_head = 1'b0;
        in_valid = 1'b1; in_instr = 32'hDEAD_BEEF; in_pc = 32'h30C;
        tick();
        idle();
        checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL flush_count got=%0d exp=0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_valid got=%b exp=0", out_valid); end
        pushOne(32'hE0, 32'h400);
        checks++; if (out_instr !== 32'hE0) begin errors++; $display("[TB] FAIL post_flush_head got=%h exp=e0", out_instr); end
        checks++; if (count !== 3'd1) begin errors++; $display("[TB] FAIL post_flush_count got=%0d exp=1", count); end
        out_ready = 1'b1; tick(); idle();
    endtask

    task automatic test_keep_head();
        pushOne(32'hF0, 32'h500);
        pushOne(32'hF1, 32'h504);
        pushOne(32'hF2, 32'h508);
        flush = 1'b1; flush_keep_head = 1'b1; out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h99; in_pc = 32'h50C;
        tick();
        idle();
        checks++; if (count !== 3'd1) begin errors++; $display("[TB] FAIL keep_count got=%0d exp=1", count); end
        checks++; if (out_instr !== 32'hF0) begin errors++; $display("[TB] FAIL keep_head got=%h exp=f0", out_instr); end
        out_ready = 1'b1; tick(); idle();
        flush = 1'b1; flush_keep_head = 1'b1;
        in_valid = 1'b1; in_instr = 32'h5A; in_pc = 32'h600;
        tick();
        idle();
        checks++; if (count !== 3'd1) begin errors++; $display("[TB] FAIL slot_count got=%0d exp=1", count); end
        checks++; if (out_instr !== 32'h5A) begin errors++; $display("[TB] FAIL slot_head got=%h exp=5a", out_instr); end
        checks++; if (out_pc !== 32'h600) begin errors++; $display("[TB] FAIL slot_pc got=%h exp=600", out_pc); end
        flush = 1'b1; flush_keep_head = 1'b1; out_ready = 1'b1;
        tick();
        idle();
        checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL keep_pop_count got=%0d exp=0", count); end
        pushOne(32'h77, 32'h700);
        checks++; if (out_instr !== 32'h77) begin errors++; $display("[TB] FAIL keep_pop_next got=%h exp=77", out_instr); end
        out_ready = 1'b1; tick(); idle();
    endtask

    task automatic test_reset_midstream();
        pushOne(32'h70, 32'h800);
        pushOne(32'h71, 32'h804);
        pushOne(32'h72, 32'h808);
        rst = 1'b0;
        in_valid = 1'b1; in_instr = 32'h73; in_pc = 32'h80C; out_ready = 1'b1;
        tick();
        rst = 1'b1;
        idle();
        checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL midreset_count got=%0d exp=0", count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL midreset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_valid got=%b exp=0", out_valid); end
        pushOne(32'h88, 32'h900);
        checks++; if (count !== 3'd1) begin errors++; $display("[TB] FAIL midreset_push_count got=%0d exp=1", count); end
        checks++; if (out_instr !== 32'h88) begin errors++; $display("[TB] FAIL midreset_push_head got=%h exp=88", out_instr); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain_wrap();
        test_back_to_back();
        test_flush();
        test_keep_head();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
